// File: rtl/tx_fifo_buffer.sv
// tx_fifo_buffer
// Transmit-side FIFO. The host side pushes words, and the TX serializer pops them
// over a valid/ready handshake. The head word sits in a registered
// first-word-fall-through output stage. Storage memory holds the words behind it.
// count covers both the memory and the output register.
module tx_fifo_buffer #(
    parameter int DATA_WIDTH   = 12,
    parameter int ADDRBIT      = 5,
    parameter int FIFO_DEPTH   = 32,
    parameter int AFULL_THRESH = 28
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  tx_ready,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic [ADDRBIT:0]      count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  overflow,
    input  logic                  clr_err
);

    localparam logic [ADDRBIT:0]   FULL_CNT  = FIFO_DEPTH[ADDRBIT:0];
    localparam logic [ADDRBIT:0]   AFULL_CNT = AFULL_THRESH[ADDRBIT:0];
    localparam logic [ADDRBIT:0]   CNT_ONE   = 1;
    localparam logic [ADDRBIT-1:0] PTR_ONE   = 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDRBIT-1:0]    wr_ptr;
    logic [ADDRBIT-1:0]    rd_ptr;
    logic [ADDRBIT:0]      count_next;

    logic push;
    logic pop;
    logic load;
    logic mem_nonempty;
    logic mem_rd;
    logic mem_wr;

    // A push is accepted only against the registered full flag.
    // This means a pop in the same cycle cannot make room for it.
    assign push = wr_en & ~full;
    assign pop  = tx_valid & tx_ready;

    // The output register reloads when it is empty or being consumed.
    assign load = ~tx_valid | pop;

    // The memory holds every counted word except the one in the output register.
    assign mem_nonempty = (count != {{ADDRBIT{1'b0}}, tx_valid});

    // Refill the output register from memory first. If memory is empty, bypass the
    // incoming word straight into the output register. Otherwise the word goes to memory.
    assign mem_rd = load & mem_nonempty;
    assign mem_wr = push & ~(load & ~mem_nonempty) & ~flush;

    // Next occupancy: +1 on push, -1 on pop, unchanged when both or neither occur.
    always_comb begin
        // NOTE: assign a default before any branch so always_comb can never infer a latch.
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    // Storage array write port.
    // NOTE: the memory is deliberately left out of reset. Occupancy is tracked by
    // the pointers and count, so stale contents are never presented.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Read and write pointers. They wrap naturally modulo FIFO_DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: registered state uses non-blocking assignments only, so every
            // flop samples pre-edge values regardless of block ordering.
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (mem_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (mem_rd) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // First-word-fall-through output register that drives the serializer.
    // It has no combinational path from wr_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else if (flush) begin
            tx_valid <= 1'b0;
        end else if (load) begin
            if (mem_rd) begin
                tx_data  <= mem[rd_ptr];
                tx_valid <= 1'b1;
            end else if (push) begin
                tx_data  <= wr_data;
                tx_valid <= 1'b1;
            end else begin
                tx_valid <= 1'b0;
            end
        end
    end

    // Occupancy count and flags. Each flag is registered from the next count,
    // so the flags always agree with count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            almost_full <= 1'b0;
        end else if (flush) begin
            count       <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            almost_full <= 1'b0;
        end else begin
            count       <= count_next;
            full        <= (count_next == FULL_CNT);
            empty       <= (count_next == '0);
            almost_full <= (count_next >= AFULL_CNT);
        end
    end

    // Sticky overflow. A rejected push sets it even when clr_err is asserted in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end else if (clr_err) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tx_fifo_buffer.sv
// tb_tx_fifo_buffer
// Directed stimulus with a scoreboard. Each accepted push queues its word.
// A monitor pops and compares on every handshake, and the flags and count are
// checked directly against hand-computed values.
module tb_tx_fifo_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        wr_en = 1'b0;
    logic [11:0] wr_data = '0;
    logic        tx_ready = 1'b0;
    logic        clr_err = 1'b0;
    logic        tx_valid;
    logic [11:0] tx_data;
    logic [5:0]  count;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        overflow;

    int vectors = 0;
    int miscompares = 0;
    logic [11:0] exp_q[$];

    tx_fifo_buffer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .tx_ready    (tx_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .overflow    (overflow),
        .clr_err     (clr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a push request for one cycle. Accepted words are queued as expected output.
    task automatic push_word(input logic [11:0] d, input bit accepted);
        wr_en   = 1'b1;
        wr_data = d;
        if (accepted) exp_q.push_back(d);
        step();
        wr_en = 1'b0;
    endtask

    // Drain with tx_ready high until empty, within a bounded number of cycles.
    task automatic drain(input int max_cycles);
        int n = 0;
        tx_ready = 1'b1;
        while (!empty && n < max_cycles) begin
            step();
            n++;
        end
        tx_ready = 1'b0;
        check("drain_empty", {31'd0, empty}, 32'd1);
        check("drain_sb_empty", exp_q.size(), 32'd0);
    endtask

    // Monitor: every handshake must deliver the oldest outstanding word.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && !flush && tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_pop: got 0x%0h expected none at %0t", tx_data, $time);
                end else begin
                    check("tx_data_pop", {20'd0, tx_data}, {20'd0, exp_q.pop_front()});
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1. Reset state, then reset during traffic.
        step();
        step();
        rst_n = 1'b1;
        step();
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_count", {26'd0, count}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_afull", {31'd0, almost_full}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_tx_data", {20'd0, tx_data}, 32'h000);

        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_en   = 1'b1;
            wr_data = 12'h100 + 12'(i);
            exp_q.push_back(wr_data);
            step();
        end
        wr_en    = 1'b0;
        tx_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("midrst_count", {26'd0, count}, 32'd0);
        check("midrst_empty", {31'd0, empty}, 32'd1);
        check("midrst_full", {31'd0, full}, 32'd0);
        check("midrst_overflow", {31'd0, overflow}, 32'd0);
        check("midrst_tx_data", {20'd0, tx_data}, 32'h000);
        step();
        rst_n = 1'b1;
        step();

        // 2. Bypass into the empty FIFO, then hold under backpressure and pop.
        push_word(12'hABC, 1'b1);
        check("byp_tx_valid", {31'd0, tx_valid}, 32'd1);
        check("byp_tx_data", {20'd0, tx_data}, 32'hABC);
        check("byp_count", {26'd0, count}, 32'd1);
        check("byp_empty", {31'd0, empty}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_tx_valid", {31'd0, tx_valid}, 32'd1);
            check("hold_tx_data", {20'd0, tx_data}, 32'hABC);
        end
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        check("pop1_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("pop1_empty", {31'd0, empty}, 32'd1);
        check("pop1_count", {26'd0, count}, 32'd0);

        // 3. Fill to full under backpressure, then reject the 33rd push.
        for (int i = 0; i < 32; i++) begin
            push_word(12'(i), 1'b1);
            check("fill_count", {26'd0, count}, 32'(i + 1));
            check("fill_afull", {31'd0, almost_full}, {31'd0, (i + 1) >= 28});
            check("fill_full", {31'd0, full}, {31'd0, (i + 1) == 32});
        end
        push_word(12'hFFF, 1'b0);
        check("ovf_set", {31'd0, overflow}, 32'd1);
        check("ovf_count", {26'd0, count}, 32'd32);
        check("ovf_full", {31'd0, full}, 32'd1);

        // 6. clr_err alone clears overflow. A rejected push in the same cycle keeps it set.
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("clr_alone", {31'd0, overflow}, 32'd0);
        clr_err = 1'b1;
        push_word(12'hFFE, 1'b0);
        clr_err = 1'b0;
        check("clr_vs_set", {31'd0, overflow}, 32'd1);
        check("clr_vs_set_count", {26'd0, count}, 32'd32);

        // When full, a push is rejected even while a pop occurs in the same cycle.
        tx_ready = 1'b1;
        push_word(12'hFFD, 1'b0);
        check("full_pushpop_count", {26'd0, count}, 32'd31);
        check("full_pushpop_full", {31'd0, full}, 32'd0);
        check("full_pushpop_afull", {31'd0, almost_full}, 32'd1);
        drain(40);

        // 4. Steady state at count 5. Push and pop every cycle for 100 words.
        for (int i = 0; i < 5; i++) push_word(12'h200 + 12'(i), 1'b1);
        check("steady_start_count", {26'd0, count}, 32'd5);
        tx_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            push_word(12'h300 + 12'(i), 1'b1);
            check("steady_count", {26'd0, count}, 32'd5);
        end
        drain(10);

        // 5. Flush has priority over a simultaneous push and pop.
        for (int i = 0; i < 10; i++) push_word(12'h400 + 12'(i), 1'b1);
        check("preflush_count", {26'd0, count}, 32'd10);
        flush    = 1'b1;
        tx_ready = 1'b1;
        wr_en    = 1'b1;
        wr_data  = 12'h4FF;
        step();
        flush    = 1'b0;
        tx_ready = 1'b0;
        wr_en    = 1'b0;
        exp_q.delete();
        check("flush_count", {26'd0, count}, 32'd0);
        check("flush_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("flush_empty", {31'd0, empty}, 32'd1);
        check("flush_overflow_kept", {31'd0, overflow}, 32'd1);
        push_word(12'h555, 1'b1);
        check("postflush_tx_valid", {31'd0, tx_valid}, 32'd1);
        check("postflush_tx_data", {20'd0, tx_data}, 32'h555);
        check("postflush_count", {26'd0, count}, 32'd1);
        drain(5);

        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
